// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester, holding-register and register-file port bundle for regfile_arbiter
interface regfile_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ack;

    logic              pc_req;
    logic              pc_we;
    logic [DATA_W-1:0] pc_wdata;
    logic              pc_ack;
    logic [DATA_W-1:0] pc_rdata;

    logic              op_req;
    logic [ADDR_W-1:0] op_addr_a;
    logic [ADDR_W-1:0] op_addr_b;
    logic              op_ack;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic [ADDR_W-1:0] rf_addr;
    logic              rf_rd;
    logic              rf_wr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_wdata_oe;
    logic [DATA_W-1:0] rf_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  wb_req, wb_addr, wb_data,
        input  pc_req, pc_we, pc_wdata,
        input  op_req, op_addr_a, op_addr_b,
        input  rf_rdata,
        output wb_ack, pc_ack, pc_rdata, op_ack, op_a, op_b,
        output rf_addr, rf_rd, rf_wr, rf_wdata, rf_wdata_oe, busy
    );

    // Requesters plus the register file itself
    modport master (
        output wb_req, wb_addr, wb_data,
        output pc_req, pc_we, pc_wdata,
        output op_req, op_addr_a, op_addr_b,
        output rf_rdata,
        input  wb_ack, pc_ack, pc_rdata, op_ack, op_a, op_b,
        input  rf_addr, rf_rd, rf_wr, rf_wdata, rf_wdata_oe, busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - single-port register file access arbiter (writeback > pc/op round-robin)
module regfile_arbiter #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 4,
    parameter logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15)
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_arbiter_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WB     = 4'd1,
        S_PC_WR  = 4'd2,
        S_PC_RD  = 4'd3,
        S_PC_CAP = 4'd4,
        S_OP_A   = 4'd5,
        S_OP_B   = 4'd6,
        S_OP_CAP = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t state;
    state_t state_nx;
    logic   favour_pc;   // round-robin flag: 1 = pc wins a pc/op tie
    logic   owner_op;    // which port DONE acknowledges: 0 = pc, 1 = op
    logic   op_same;     // operand pair uses one address, single read
    logic   grant_pc;
    logic   grant_op;

    // Next state, grants and all state-decoded outputs; everything defaults to 0
    always_comb begin
        state_nx        = state;
        grant_pc        = 1'b0;
        grant_op        = 1'b0;
        bus.wb_ack      = 1'b0;
        bus.pc_ack      = 1'b0;
        bus.op_ack      = 1'b0;
        bus.rf_addr     = '0;
        bus.rf_rd       = 1'b0;
        bus.rf_wr       = 1'b0;
        bus.rf_wdata    = '0;
        bus.rf_wdata_oe = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.wb_req) begin
                    state_nx = S_WB;
                end else if (bus.pc_req && (!bus.op_req || favour_pc)) begin
                    grant_pc = 1'b1;
                    state_nx = bus.pc_we ? S_PC_WR : S_PC_RD;
                end else if (bus.op_req) begin
                    grant_op = 1'b1;
                    state_nx = S_OP_A;
                end
            end
            S_WB: begin
                bus.rf_wr       = 1'b1;
                bus.rf_addr     = bus.wb_addr;
                bus.rf_wdata    = bus.wb_data;
                bus.rf_wdata_oe = 1'b1;
                bus.wb_ack      = 1'b1;
                state_nx        = S_IDLE;
            end
            S_PC_WR: begin
                bus.rf_wr       = 1'b1;
                bus.rf_addr     = PC_ADDR;
                bus.rf_wdata    = bus.pc_wdata;
                bus.rf_wdata_oe = 1'b1;
                bus.pc_ack      = 1'b1;
                state_nx        = S_IDLE;
            end
            S_PC_RD: begin
                bus.rf_rd   = 1'b1;
                bus.rf_addr = PC_ADDR;
                state_nx    = S_PC_CAP;
            end
            S_PC_CAP: begin
                state_nx = S_DONE;
            end
            S_OP_A: begin
                bus.rf_rd   = 1'b1;
                bus.rf_addr = bus.op_addr_a;
                state_nx    = (bus.op_addr_b == bus.op_addr_a) ? S_OP_CAP : S_OP_B;
            end
            S_OP_B: begin
                bus.rf_rd   = 1'b1;
                bus.rf_addr = bus.op_addr_b;
                state_nx    = S_OP_CAP;
            end
            S_OP_CAP: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                bus.pc_ack = ~owner_op;
                bus.op_ack = owner_op;
                state_nx   = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.busy = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Round-robin flag flips on every pc/op grant; owner remembers who DONE serves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_pc <= 1'b1;
            owner_op  <= 1'b0;
        end else if (grant_pc || grant_op) begin
            favour_pc <= ~favour_pc;
            owner_op  <= grant_op;
        end
    end

    // Remember the equal-address case so OP_CAP can fill both operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_same <= 1'b0;
        end else if (state == S_OP_A) begin
            op_same <= (bus.op_addr_b == bus.op_addr_a);
        end
    end

    // Holding registers load only in their capture states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc_rdata <= '0;
            bus.op_a     <= '0;
            bus.op_b     <= '0;
        end else begin
            case (state)
                S_PC_CAP: bus.pc_rdata <= bus.rf_rdata;
                S_OP_B:   bus.op_a     <= bus.rf_rdata;
                S_OP_CAP: begin
                    bus.op_b <= bus.rf_rdata;
                    if (op_same) begin
                        bus.op_a <= bus.rf_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - randomized and directed bench for regfile_arbiter against a transaction-level model
module tb_regfile_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    regfile_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) rfb ();

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PC_ADDR(4'd15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rfb)
    );

    // Register file: write on strobe with bus driven, read data one cycle after rf_rd
    logic [DW-1:0] rf_mem [16];
    always @(posedge clk) begin
        if (rfb.rf_wr && rfb.rf_wdata_oe) rf_mem[rfb.rf_addr] <= rfb.rf_wdata;
        rfb.rf_rdata <= rfb.rf_rd ? rf_mem[rfb.rf_addr] : 16'h5A5A;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference model: kinds 0=wb 1=pc write 2=pc read 3=operand pair
    int            cyc = 0;
    bit            m_active = 0;
    int            m_g = 0;
    int            m_kind = 0;
    logic [3:0]    m_a, m_b;
    logic [DW-1:0] m_d;
    bit            m_favour_pc = 1;
    int            m_free_from = 0;
    logic [DW-1:0] m_mem [16];
    logic [DW-1:0] e_op_a = '0, e_op_b = '0, e_pc = '0;
    int            ack_log[$];
    int            exp_order[7] = '{0, 1, 2, 1, 2, 1, 2};

    task automatic model_step();
        int         o;
        int         lat;
        logic [2:0] e_acks;
        logic       e_rd, e_wr;
        logic [3:0] e_addr;
        logic [DW-1:0] e_wd;
        e_acks = '0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
        o = cyc - m_g;
        if (m_active) begin
            case (m_kind)
                0: if (o == 1) begin e_wr = 1; e_addr = m_a; e_wd = m_d; e_acks = 3'b100; end
                1: if (o == 1) begin e_wr = 1; e_addr = 4'd15; e_wd = m_d; e_acks = 3'b010; end
                2: begin
                    if (o == 1) begin e_rd = 1; e_addr = 4'd15; end
                    if (o == 3) e_acks = 3'b010;
                end
                default: begin
                    if (o == 1) begin e_rd = 1; e_addr = m_a; end
                    if (o == 2 && m_a != m_b) begin e_rd = 1; e_addr = m_b; end
                    if (o == ((m_a == m_b) ? 3 : 4)) e_acks = 3'b001;
                end
            endcase
        end
        check_eq("busy", rfb.busy, (cyc < m_free_from));
        check_eq("acks", {rfb.wb_ack, rfb.pc_ack, rfb.op_ack}, e_acks);
        check_eq("rf_rd", rfb.rf_rd, e_rd);
        check_eq("rf_wr", rfb.rf_wr, e_wr);
        check_eq("rf_wdata_oe", rfb.rf_wdata_oe, e_wr);
        check_eq("rf_addr", rfb.rf_addr, e_addr);
        check_eq("rf_wdata", rfb.rf_wdata, e_wd);
        if (!(m_active && m_kind == 3)) begin
            check_eq("op_a_hold", rfb.op_a, e_op_a);
            check_eq("op_b_hold", rfb.op_b, e_op_b);
        end
        if (!(m_active && m_kind == 2)) check_eq("pc_rdata_hold", rfb.pc_rdata, e_pc);
        if (e_acks != 0) begin
            case (m_kind)
                0: begin m_mem[m_a] = m_d; ack_log.push_back(0); end
                1: begin m_mem[15] = m_d; ack_log.push_back(1); end
                2: begin
                    e_pc = m_mem[15];
                    check_eq("pc_rdata", rfb.pc_rdata, e_pc);
                    ack_log.push_back(1);
                end
                default: begin
                    e_op_a = m_mem[m_a];
                    e_op_b = m_mem[m_b];
                    check_eq("op_a", rfb.op_a, e_op_a);
                    check_eq("op_b", rfb.op_b, e_op_b);
                    ack_log.push_back(2);
                end
            endcase
            m_active = 0;
        end
        if (!m_active && cyc >= m_free_from) begin
            lat = 0;
            if (rfb.wb_req) begin
                m_kind = 0; m_a = rfb.wb_addr; m_d = rfb.wb_data; lat = 1;
            end else if (rfb.pc_req && rfb.op_req) begin
                if (m_favour_pc) begin
                    m_kind = rfb.pc_we ? 1 : 2; m_d = rfb.pc_wdata; lat = rfb.pc_we ? 1 : 3;
                end else begin
                    m_kind = 3; m_a = rfb.op_addr_a; m_b = rfb.op_addr_b; lat = (m_a == m_b) ? 3 : 4;
                end
                m_favour_pc = !m_favour_pc;
            end else if (rfb.pc_req) begin
                m_kind = rfb.pc_we ? 1 : 2; m_d = rfb.pc_wdata; lat = rfb.pc_we ? 1 : 3;
                m_favour_pc = !m_favour_pc;
            end else if (rfb.op_req) begin
                m_kind = 3; m_a = rfb.op_addr_a; m_b = rfb.op_addr_b; lat = (m_a == m_b) ? 3 : 4;
                m_favour_pc = !m_favour_pc;
            end
            if (lat != 0) begin
                m_active    = 1;
                m_g         = cyc;
                m_free_from = cyc + lat + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check_eq("reset_outs", {rfb.wb_ack, rfb.pc_ack, rfb.op_ack, rfb.busy, rfb.rf_rd,
                                        rfb.rf_wr, rfb.rf_wdata_oe, rfb.rf_addr, rfb.rf_wdata,
                                        rfb.op_a, rfb.op_b, rfb.pc_rdata}, '0);
                m_active = 0; m_free_from = 0; m_favour_pc = 1;
                e_op_a = '0; e_op_b = '0; e_pc = '0;
            end else begin
                model_step();
            end
        end
    end

    // Requester side: hold req until ack seen, then drop right after the edge ending the ack cycle
    task automatic wait_ack(input int who);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((who == 0 && rfb.wb_ack) || (who == 1 && rfb.pc_ack) || (who == 2 && rfb.op_ack)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq($sformatf("ack_timeout_%0d", who), 0, 1);
        @(posedge clk) #1;
    endtask

    task automatic req_wb(input logic [3:0] a, input logic [DW-1:0] d);
        @(posedge clk) #1;
        rfb.wb_addr = a; rfb.wb_data = d; rfb.wb_req = 1;
        wait_ack(0);
        rfb.wb_req = 0;
    endtask

    task automatic req_pc(input logic we, input logic [DW-1:0] d);
        @(posedge clk) #1;
        rfb.pc_we = we; rfb.pc_wdata = d; rfb.pc_req = 1;
        wait_ack(1);
        rfb.pc_req = 0;
    endtask

    task automatic req_op(input logic [3:0] a, input logic [3:0] b);
        @(posedge clk) #1;
        rfb.op_addr_a = a; rfb.op_addr_b = b; rfb.op_req = 1;
        wait_ack(2);
        rfb.op_req = 0;
    endtask

    task automatic do_reset();
        @(posedge clk) #2;
        rst_n = 0;
        rfb.wb_req = 0; rfb.pc_req = 0; rfb.op_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int cnt;
        rfb.wb_req = 0; rfb.wb_addr = '0; rfb.wb_data = '0;
        rfb.pc_req = 0; rfb.pc_we = 0; rfb.pc_wdata = '0;
        rfb.op_req = 0; rfb.op_addr_a = '0; rfb.op_addr_b = '0;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < 16; i++) req_wb(4'(i), 16'($urandom));

        req_wb(4'd3, 16'hBEEF);
        req_op(4'd3, 4'd3);
        check_eq("same_addr_op_a", rfb.op_a, 16'hBEEF);
        check_eq("same_addr_op_b", rfb.op_b, 16'hBEEF);

        req_wb(4'd1, 16'h0011);
        req_wb(4'd2, 16'h0022);
        req_op(4'd1, 4'd2);
        check_eq("pair_op_a", rfb.op_a, 16'h0011);
        check_eq("pair_op_b", rfb.op_b, 16'h0022);

        req_pc(1'b1, 16'h00A1);
        req_pc(1'b0, 16'h0000);
        check_eq("pc_read_back", rfb.pc_rdata, 16'h00A1);

        @(posedge clk) #1;
        rfb.pc_we = 0; rfb.pc_req = 1;
        @(posedge clk) #1;
        rfb.pc_req = 0;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (rfb.pc_ack) cnt++; end
        check_eq("pc_drop_ack_count", cnt, 1);

        @(posedge clk) #1;
        rfb.op_addr_a = 4'd1; rfb.op_addr_b = 4'd2; rfb.op_req = 1;
        @(posedge clk) #1;
        @(posedge clk) #2;
        check_eq("op_b_rd_before_reset", rfb.rf_rd, 1);
        rst_n = 0;
        rfb.op_req = 0;
        #1;
        check_eq("reset_rf_rd_now", rfb.rf_rd, 0);
        check_eq("reset_op_a_now", rfb.op_a, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (rfb.op_ack) cnt++; end
        check_eq("no_op_ack_after_reset", cnt, 0);

        do_reset();
        ack_log.delete();
        fork
            req_wb(4'd5, 16'($urandom));
            begin repeat (3) req_pc(1'($urandom), 16'($urandom)); end
            begin repeat (3) req_op(4'($urandom), 4'($urandom)); end
        join
        check_eq("grant_order_len", ack_log.size(), 7);
        for (int i = 0; i < 7 && i < ack_log.size(); i++)
            check_eq($sformatf("grant_order_%0d", i), ack_log[i], exp_order[i]);

        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    req_wb(4'($urandom), 16'($urandom));
                end
            end
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    req_pc(1'($urandom), 16'($urandom));
                end
            end
            begin
                repeat (40) begin
                    logic [3:0] a;
                    logic [3:0] b;
                    a = 4'($urandom);
                    b = ($urandom_range(0, 2) == 0) ? a : 4'($urandom);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    req_op(a, b);
                end
            end
        join

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
